font_dma_sched: RTL and testbench

//  Shares the single synchronous font glyph ROM between SPR_CNT sprite engines.

---
 rtl/font_dma_sched.sv | 145 ++++++++++++++
 tb/tb_font_dma_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_dma_sched.sv
// Round-robin scheduler sharing one synchronous font ROM between sprite engines.
// One ROM read per cycle, granted only inside the horizontal-blanking DMA window.
module font_dma_sched #(
  parameter int SPR_CNT   = 14,
  parameter int CORDW     = 16,
  parameter int ADDRW     = 9,
  parameter int DATAW     = 8,
  parameter int WIN_START = -2*SPR_CNT,
  parameter int WIN_LEN   = 2*SPR_CNT
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix_n,
  input  logic signed [CORDW-1:0]    sx,
  input  logic [SPR_CNT-1:0]         req,
  input  logic [SPR_CNT*ADDRW-1:0]   req_addr,
  output logic                       rom_en,
  output logic [ADDRW-1:0]           rom_addr,
  input  logic [DATAW-1:0]           rom_data,
  output logic [SPR_CNT-1:0]         gnt,
  output logic [SPR_CNT-1:0]         rsp_valid,
  output logic [DATAW-1:0]           rsp_data,
  output logic                       miss,
  output logic [15:0]                miss_cnt,
  output logic                       o_dbg_state,
  output logic [$clog2(SPR_CNT)-1:0] o_dbg_rr_ptr
);
  localparam int PW = $clog2(SPR_CNT);
  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [PW:0]             SPR_N    = (PW+1)'(SPR_CNT);
  localparam logic [CW-1:0]           CNT_LAST = CW'(WIN_LEN-1);
  localparam logic signed [CORDW-1:0] SX_OPEN  = CORDW'(WIN_START);

  typedef enum logic {IDLE = 1'b0, WINDOW = 1'b1} state_t;

  // Handshake: req[i] is a level held by sprite i until rsp_valid[i]; gnt/rom_en pulse
  // one cycle after the request is sampled, rsp_valid follows one cycle later with rsp_data.
  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [SPR_CNT-1:0] r_served;
  logic [PW-1:0]      r_rr_ptr;
  logic               r_rom_en;
  logic [ADDRW-1:0]   r_rom_addr;
  logic [SPR_CNT-1:0] r_gnt;
  logic [SPR_CNT-1:0] r_rsp_valid;
  logic               r_miss;
  logic [15:0]        r_miss_cnt;

  logic [SPR_CNT-1:0] w_elig;
  logic [SPR_CNT-1:0] w_win_oh;
  logic [PW-1:0]      w_winner;
  logic [PW:0]        w_idx;
  logic [PW:0]        w_inc;
  logic [PW-1:0]      w_rr_nxt;
  logic               w_found;
  logic               w_open;
  logic               w_last;
  logic               w_grant;
  logic               w_miss_now;

  assign w_elig = req & ~r_served;

  // Scan from the highest rotated offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = SPR_CNT-1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= SPR_N) w_idx = w_idx - SPR_N;
      if (w_elig[w_idx[PW-1:0]]) begin
        w_winner = w_idx[PW-1:0];
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_inc    = {1'b0, w_winner} + (PW+1)'(1);
    w_rr_nxt = (w_inc == SPR_N) ? '0 : w_inc[PW-1:0];
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_open) w_state_nxt = WINDOW;
      WINDOW:  if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Miss looks at the mask after the last-cycle grant is accounted for.
  always_comb begin
    w_open     = (r_state == IDLE) && (sx == SX_OPEN);
    w_last     = (r_state == WINDOW) && (r_cnt == CNT_LAST);
    w_grant    = (r_state == WINDOW) && w_found;
    w_win_oh   = w_grant ? (SPR_CNT'(1) << w_winner) : '0;
    w_miss_now = w_last && (|(w_elig & ~w_win_oh));
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_cnt       <= '0;
      r_served    <= '0;
      r_rr_ptr    <= '0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_miss      <= 1'b0;
      r_miss_cnt  <= '0;
    end else begin
      r_rsp_valid <= r_gnt;
      r_rom_en    <= w_grant;
      r_gnt       <= w_win_oh;
      r_miss      <= w_miss_now;
      if (w_grant) begin
        r_rom_addr <= req_addr[w_winner*ADDRW +: ADDRW];
        r_served   <= r_served | w_win_oh;
        r_rr_ptr   <= w_rr_nxt;
      end
      if (w_open) begin
        r_served <= '0;
        r_cnt    <= '0;
      end else if (r_state == WINDOW) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_miss_now && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign rom_en       = r_rom_en;
  assign rom_addr     = r_rom_addr;
  assign gnt          = r_gnt;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = rom_data;
  assign miss         = r_miss;
  assign miss_cnt     = r_miss_cnt;
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;
endmodule

// File: tb/tb_font_dma_sched.sv
// Directed bench for font_dma_sched: a default-window instance (dut_a) and a
// 4-cycle-window instance (dut_b) for the miss and saturation cases.
module tb_font_dma_sched;
  localparam int SPR_CNT = 14;
  localparam int CORDW   = 16;
  localparam int ADDRW   = 9;
  localparam int DATAW   = 8;
  localparam int W       = 4 + DATAW;

  logic                     clk_pix = 1'b0;
  logic                     rst_pix_n = 1'b0;
  logic signed [CORDW-1:0]  sx = '0;
  logic [SPR_CNT-1:0]       req_a = '0;
  logic [SPR_CNT-1:0]       req_b = '0;
  logic [SPR_CNT*ADDRW-1:0] req_addr = '0;

  logic               rom_en_a, rom_en_b, miss_a, miss_b, st_a, st_b;
  logic [ADDRW-1:0]   rom_addr_a, rom_addr_b;
  logic [DATAW-1:0]   rom_data_a = '0, rom_data_b = '0, rsp_data_a, rsp_data_b;
  logic [SPR_CNT-1:0] gnt_a, gnt_b, rsp_valid_a, rsp_valid_b;
  logic [15:0]        miss_cnt_a, miss_cnt_b;
  logic [3:0]         rr_a, rr_b;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];
  logic [ADDRW-1:0] last_addr_a = '0;
  int n_tests = 0;
  int n_fail  = 0;

  font_dma_sched dut_a (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .req(req_a), .req_addr(req_addr),
    .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .gnt(gnt_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .miss(miss_a), .miss_cnt(miss_cnt_a),
    .o_dbg_state(st_a), .o_dbg_rr_ptr(rr_a)
  );

  font_dma_sched #(.WIN_LEN(4)) dut_b (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .req(req_b), .req_addr(req_addr),
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .gnt(gnt_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .miss(miss_b), .miss_cnt(miss_cnt_b),
    .o_dbg_state(st_b), .o_dbg_rr_ptr(rr_b)
  );

  // Clock and synchronous ROM models
  always #5 clk_pix = ~clk_pix;

  function automatic logic [DATAW-1:0] rom_fn(input logic [ADDRW-1:0] a);
    return a[7:0] ^ 8'h5C;
  endfunction

  always @(posedge clk_pix) begin
    if (rom_en_a) rom_data_a <= rom_fn(rom_addr_a);
    if (rom_en_b) rom_data_b <= rom_fn(rom_addr_b);
  end

  function automatic int oh_idx(input logic [SPR_CNT-1:0] v);
    int r;
    r = -1;
    for (int i = SPR_CNT-1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // One sweep of sx through the dut_a window; late_mask joins req when sx reaches late_sx.
  task automatic run_window_a(input logic [SPR_CNT-1:0] req_init, input logic [SPR_CNT-1:0] late_mask,
                              input int late_sx, output int cnt, output int first, output int last,
                              output int misses, output int first_sx);
    int g;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    cnt = 0; first = -1; last = -1; misses = 0; first_sx = 0;
    sx = -16'sd30;
    req_a = req_init;
    for (int j = 0; j < 36; j++) begin
      tick();
      if (rsp_valid_a != '0) begin
        if (exp_q.size() == 0) begin
          check("a_rsp_spurious", 32'(rsp_valid_a), 32'd0);
        end else begin
          exp = exp_q.pop_front();
          got = {4'(oh_idx(rsp_valid_a)), rsp_data_a};
          check("a_rsp_onehot", 32'($onehot(rsp_valid_a)), 32'd1);
          check("a_rsp_idx_data", 32'(got), 32'(exp));
        end
      end
      if (gnt_a != '0) begin
        g = oh_idx(gnt_a);
        check("a_gnt_onehot", 32'($onehot(gnt_a)), 32'd1);
        check("a_rom_en", 32'(rom_en_a), 32'd1);
        check("a_rom_addr", 32'(rom_addr_a), 32'(g*8));
        exp_q.push_back({4'(g), rom_fn(ADDRW'(g*8))});
        last_addr_a = ADDRW'(g*8);
        if (first < 0) begin
          first = g;
          first_sx = int'(sx);
        end
        last = g;
        cnt++;
      end else begin
        check("a_rom_en_low", 32'(rom_en_a), 32'd0);
        check("a_rom_addr_hold", 32'(rom_addr_a), 32'(last_addr_a));
      end
      if (miss_a) misses++;
      sx = sx + 16'sd1;
      if (int'(sx) == late_sx) req_a = req_init | late_mask;
    end
  endtask

  // One dut_b window with all requests held; grants must follow exp_first in order.
  task automatic run_window_b(input logic retrig, input int exp_first, output int cnt, output int misses);
    int g;
    logic done;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    cnt = 0; misses = 0; done = 1'b0;
    sx = -16'sd30;
    req_b = '1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (rsp_valid_b != '0) begin
        if (exp_qb.size() == 0) begin
          check("b_rsp_spurious", 32'(rsp_valid_b), 32'd0);
        end else begin
          exp = exp_qb.pop_front();
          got = {4'(oh_idx(rsp_valid_b)), rsp_data_b};
          check("b_rsp_idx_data", 32'(got), 32'(exp));
        end
      end
      if (gnt_b != '0) begin
        g = oh_idx(gnt_b);
        check("b_gnt_order", 32'(g), 32'((exp_first + cnt) % SPR_CNT));
        check("b_rom_addr", 32'(rom_addr_b), 32'(g*8));
        exp_qb.push_back({4'(g), rom_fn(ADDRW'(g*8))});
        cnt++;
      end
      if (miss_b) misses++;
      sx = sx + 16'sd1;
      if (retrig && !done && sx == -16'sd26) begin
        sx = -16'sd28;
        done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [SPR_CNT-1:0] req;
    int exp_cnt;
    int exp_first;
    int exp_last;
    int exp_rr;
    int exp_miss;
  } win_vec_t;

  win_vec_t vecs[8];

  initial begin
    int cnt, first, last, misses, fsx;

    vecs[0] = '{14'h3FFF, 14, 0, 13, 0, 0};
    vecs[1] = '{14'h001F, 5, 0, 4, 5, 0};
    vecs[2] = '{14'h0088, 2, 7, 3, 4, 0};
    vecs[3] = '{14'h0088, 2, 7, 3, 4, 0};
    vecs[4] = '{14'h2000, 1, 13, 13, 0, 0};
    vecs[5] = '{14'h0000, 0, -1, -1, 0, 0};
    vecs[6] = '{14'h1002, 2, 1, 12, 13, 0};
    vecs[7] = '{14'h2001, 2, 13, 0, 1, 0};

    for (int i = 0; i < SPR_CNT; i++) req_addr[i*ADDRW +: ADDRW] = ADDRW'(i*8);

    // Reset state
    tick();
    tick();
    check("rst_rom_en", 32'(rom_en_a), 32'd0);
    check("rst_rom_addr", 32'(rom_addr_a), 32'd0);
    check("rst_gnt", 32'(gnt_a), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_miss", 32'(miss_a), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt_a), 32'd0);
    check("rst_state", 32'(st_a), 32'd0);
    check("rst_rr", 32'(rr_a), 32'd0);
    rst_pix_n = 1'b1;
    tick();

    // Table of full windows on dut_a
    for (int v = 0; v < 8; v++) begin
      run_window_a(vecs[v].req, '0, 999, cnt, first, last, misses, fsx);
      check($sformatf("v%0d_cnt", v), 32'(cnt), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_first", v), 32'(first), 32'(vecs[v].exp_first));
      check($sformatf("v%0d_last", v), 32'(last), 32'(vecs[v].exp_last));
      check($sformatf("v%0d_rr", v), 32'(rr_a), 32'(vecs[v].exp_rr));
      check($sformatf("v%0d_miss", v), 32'(misses), 32'(vecs[v].exp_miss));
      check($sformatf("v%0d_q_empty", v), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_idle", v), 32'(st_a), 32'd0);
      if (vecs[v].exp_cnt > 0) begin
        check($sformatf("v%0d_first_sx", v), 32'(fsx), 32'(-27));
        check($sformatf("v%0d_last_sx", v), 32'(fsx + cnt - 1), 32'(-27 + vecs[v].exp_cnt - 1));
      end
    end
    check("a_miss_cnt_zero", 32'(miss_cnt_a), 32'd0);

    // Late-rising request, held for the rest of the window
    run_window_a('0, 14'h0020, -17, cnt, first, last, misses, fsx);
    check("late_cnt", 32'(cnt), 32'd1);
    check("late_first", 32'(first), 32'd5);
    check("late_first_sx", 32'(fsx), 32'(-17));
    check("late_miss", 32'(misses), 32'd0);
    check("late_rr", 32'(rr_a), 32'd6);

    // Short window on dut_b: misses and round-robin continuation
    run_window_b(1'b0, 0, cnt, misses);
    check("b_w1_cnt", 32'(cnt), 32'd4);
    check("b_w1_miss", 32'(misses), 32'd1);
    check("b_w1_miss_cnt", 32'(miss_cnt_b), 32'd1);
    run_window_b(1'b0, 4, cnt, misses);
    check("b_w2_cnt", 32'(cnt), 32'd4);
    check("b_w2_miss_cnt", 32'(miss_cnt_b), 32'd2);
    run_window_b(1'b1, 8, cnt, misses);
    check("b_retrig_cnt", 32'(cnt), 32'd4);
    check("b_retrig_miss", 32'(misses), 32'd1);
    check("b_retrig_idle", 32'(st_b), 32'd0);
    check("b_retrig_q_empty", 32'(exp_qb.size()), 32'd0);

    // Saturation of the miss counter
    force dut_b.r_miss_cnt = 16'hFFFE;
    #1;
    release dut_b.r_miss_cnt;
    check("b_forced", 32'(miss_cnt_b), 32'hFFFE);
    run_window_b(1'b0, 12, cnt, misses);
    check("b_sat1_miss", 32'(misses), 32'd1);
    check("b_sat1_cnt", 32'(miss_cnt_b), 32'hFFFF);
    run_window_b(1'b0, 2, cnt, misses);
    check("b_sat2_miss", 32'(misses), 32'd1);
    check("b_sat2_cnt", 32'(miss_cnt_b), 32'hFFFF);

    // Reset on window cycle 3 with a grant in flight
    req_a = '1;
    sx = -16'sd30;
    for (int j = 0; j < 6; j++) begin
      tick();
      sx = sx + 16'sd1;
    end
    check("pre_rst_window", 32'(st_a), 32'd1);
    check("pre_rst_gnt_busy", 32'(gnt_a != '0), 32'd1);
    #2;
    rst_pix_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_a), 32'd0);
    check("mid_rst_rom_en", 32'(rom_en_a), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr_a), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("mid_rst_state", 32'(st_a), 32'd0);
    check("mid_rst_b_miss_cnt", 32'(miss_cnt_b), 32'd0);
    tick();
    tick();
    rst_pix_n = 1'b1;
    exp_q.delete();
    last_addr_a = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      sx = sx + 16'sd1;
      check("post_rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
      check("post_rst_gnt", 32'(gnt_a), 32'd0);
    end
    run_window_a('1, '0, 999, cnt, first, last, misses, fsx);
    check("post_rst_first", 32'(first), 32'd0);
    check("post_rst_cnt", 32'(cnt), 32'd14);
    check("post_rst_miss", 32'(misses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
